// File: rtl/fcl_bin_seq.sv
// fcl_bin_seq: runs a full binary MLP inference through one shared fcl_bin
// engine. The image (IN_DIM bits) is loaded PAR bits per handshake. The
// engine is then driven one input bit per cycle, one PAR-wide group of output
// neurons at a time. Each layer's results go into ping-pong hidden buffers,
// and the last layer is returned on a valid/ready port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input word handshake, in_data = PAR image bits
//   shift_cfg           per-layer engine shift, latched on the first word
//   w_addr/w_rd/w_rdata weight ROM port (1-cycle synchronous read)
//   eng_*               fcl_bin engine control/data (eng_clr = inverted rst)
//   res_valid/res_ready final layer result handshake, res_data = HID_DIM bits
//   busy, layer_idx     status
module fcl_bin_seq #(
  parameter int PAR        = 8,
  parameter int IN_DIM     = 784,
  parameter int HID_DIM    = 16,
  parameter int NUM_LAYERS = 4,
  parameter int SHIFT_W    = 5,
  parameter int WADDR_W    = 11
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [PAR-1:0]                                 in_data,
  input  logic [NUM_LAYERS*SHIFT_W-1:0]                  shift_cfg,
  output logic [WADDR_W-1:0]                             w_addr,
  output logic                                           w_rd,
  input  logic [PAR-1:0]                                 w_rdata,
  output logic                                           eng_clr,
  output logic                                           eng_en,
  output logic                                           eng_input,
  output logic [PAR-1:0]                                 eng_w,
  output logic [SHIFT_W-1:0]                             eng_shift,
  input  logic [PAR-1:0]                                 eng_output,
  output logic                                           res_valid,
  input  logic                                           res_ready,
  output logic [HID_DIM-1:0]                             res_data,
  output logic                                           busy,
  output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] layer_idx
);

  localparam int NWORDS = IN_DIM / PAR;
  localparam int NGRP   = HID_DIM / PAR;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int MAXN   = (IN_DIM > HID_DIM) ? IN_DIM : HID_DIM;
  localparam int K_W    = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam int HK_W   = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_ACCUM, S_CAPTURE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IN_DIM-1:0]             img_buf, img_nxt;
  logic [HID_DIM-1:0]            hbuf0, hbuf1, cap0_nxt, cap1_nxt;
  logic                          dst_sel;
  logic [CNT_W-1:0]              in_cnt;
  logic [GRP_W-1:0]              grp;
  logic [K_W-1:0]                k;
  logic [WADDR_W-1:0]            w_ptr;
  logic [NUM_LAYERS*SHIFT_W-1:0] shift_lat;
  logic [LIDX_W-1:0]             lidx;

  logic in_acc, last_word, last_k, last_grp, last_layer, src_bit;

  assign in_acc     = in_valid & in_ready;
  assign last_word  = (in_cnt == CNT_W'(NWORDS - 1));
  assign last_k     = (lidx == '0) ? (k == K_W'(IN_DIM - 1)) : (k == K_W'(HID_DIM - 1));
  assign last_grp   = (grp == GRP_W'(NGRP - 1));
  assign last_layer = (lidx == LIDX_W'(NUM_LAYERS - 1));

  // Words and group results are shifted in from the top, so after a complete
  // fill, word/group 0 sits at bit 0 without any variable-index writes.
  assign img_nxt  = IN_DIM'({in_data, img_buf} >> PAR);
  assign cap0_nxt = HID_DIM'({eng_output, hbuf0} >> PAR);
  assign cap1_nxt = HID_DIM'({eng_output, hbuf1} >> PAR);

  // Layer 0 reads the image; later layers read the hidden buffer not being written.
  assign src_bit = (lidx == '0) ? img_buf[k]
                 : (dst_sel ? hbuf0[k[HK_W-1:0]] : hbuf1[k[HK_W-1:0]]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_LOAD: if (in_acc) state_nxt = last_word ? S_CLEAR : S_LOAD;
      S_CLEAR:        state_nxt = S_ACCUM;
      S_ACCUM:        if (last_k) state_nxt = S_CAPTURE;
      S_CAPTURE:      state_nxt = (last_grp && last_layer) ? S_DONE : S_CLEAR;
      S_DONE:         if (res_ready) state_nxt = S_IDLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    w_rd      = 1'b0;
    eng_clr   = 1'b0;
    eng_en    = 1'b0;
    eng_input = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      S_IDLE, S_LOAD: in_ready = ~rst;
      S_CLEAR: begin
        eng_clr = 1'b1;
        w_rd    = 1'b1;
      end
      S_ACCUM: begin
        eng_en    = 1'b1;
        eng_input = src_bit;
        w_rd      = ~last_k;
      end
      S_DONE:  res_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_addr    = w_ptr;
  assign eng_w     = w_rdata;
  assign eng_shift = shift_lat[SHIFT_W-1:0];
  assign busy      = (state != S_IDLE);
  assign layer_idx = lidx;
  assign res_data  = res_valid ? (dst_sel ? hbuf1 : hbuf0) : '0;

  // Datapath: buffers, counters, weight pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_buf   <= '0;
      hbuf0     <= '0;
      hbuf1     <= '0;
      dst_sel   <= 1'b0;
      in_cnt    <= '0;
      grp       <= '0;
      k         <= '0;
      w_ptr     <= '0;
      shift_lat <= '0;
      lidx      <= '0;
    end else begin
      if (in_acc) begin
        img_buf <= img_nxt;
        in_cnt  <= last_word ? '0 : in_cnt + 1'b1;
      end

      if (state == S_IDLE && in_acc) begin
        shift_lat <= shift_cfg;
        lidx      <= '0;
        dst_sel   <= 1'b0;
        grp       <= '0;
        w_ptr     <= '0;
      end else if (state == S_DONE && res_ready) begin
        w_ptr <= '0;
      end else if (w_rd) begin
        w_ptr <= w_ptr + 1'b1;
      end

      unique case (state)
        S_CLEAR: k <= '0;
        S_ACCUM: k <= k + 1'b1;
        S_CAPTURE: begin
          if (dst_sel) hbuf1 <= cap1_nxt;
          else         hbuf0 <= cap0_nxt;
          if (!last_grp) begin
            grp <= grp + 1'b1;
          end else if (!last_layer) begin
            // The active layer's shift always sits in the low slot.
            grp       <= '0;
            lidx      <= lidx + 1'b1;
            dst_sel   <= ~dst_sel;
            shift_lat <= shift_lat >> SHIFT_W;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fcl_bin_seq.sv
module tb_fcl_bin_seq;

  localparam int PAR        = 8;
  localparam int IN_DIM     = 784;
  localparam int HID_DIM    = 16;
  localparam int NUM_LAYERS = 4;
  localparam int SHIFT_W    = 5;
  localparam int WADDR_W    = 11;
  localparam int NWORDS     = IN_DIM / PAR;
  localparam int NGRP       = HID_DIM / PAR;
  localparam int NW         = IN_DIM * HID_DIM / PAR + (NUM_LAYERS - 1) * HID_DIM * HID_DIM / PAR;
  localparam int SCFG_W     = NUM_LAYERS * SHIFT_W;
  localparam int DONE_LAT   = NGRP * (IN_DIM + 2) + (NUM_LAYERS - 1) * NGRP * (HID_DIM + 2);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [PAR-1:0]       in_data;
  logic [SCFG_W-1:0]    shift_cfg;
  logic [WADDR_W-1:0]   w_addr;
  logic                 w_rd;
  logic [PAR-1:0]       w_rdata = '0;
  logic                 eng_clr;
  logic                 eng_en;
  logic                 eng_input;
  logic [PAR-1:0]       eng_w;
  logic [SHIFT_W-1:0]   eng_shift;
  logic [PAR-1:0]       eng_output;
  logic                 res_valid;
  logic                 res_ready;
  logic [HID_DIM-1:0]   res_data;
  logic                 busy;
  logic [1:0]           layer_idx;

  always #5 clk = ~clk;

  fcl_bin_seq #(
    .PAR(PAR), .IN_DIM(IN_DIM), .HID_DIM(HID_DIM),
    .NUM_LAYERS(NUM_LAYERS), .SHIFT_W(SHIFT_W), .WADDR_W(WADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_cfg(shift_cfg),
    .w_addr(w_addr), .w_rd(w_rd), .w_rdata(w_rdata),
    .eng_clr(eng_clr), .eng_en(eng_en), .eng_input(eng_input),
    .eng_w(eng_w), .eng_shift(eng_shift), .eng_output(eng_output),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .layer_idx(layer_idx)
  );

  // Weight ROM and binary engine (XNOR-popcount, output = accumulator bit 'shift')
  logic [PAR-1:0] rom [NW];
  logic [31:0]    acc [PAR];

  initial for (int j = 0; j < PAR; j++) acc[j] = '0;

  always @(posedge clk) if (w_rd) w_rdata <= rom[w_addr];

  always @(posedge clk) begin
    for (int j = 0; j < PAR; j++) begin
      if (eng_clr) acc[j] <= '0;
      else if (eng_en && (eng_input == eng_w[j])) acc[j] <= acc[j] + 32'd1;
    end
  end

  always_comb begin
    eng_output = '0;
    for (int j = 0; j < PAR; j++) eng_output[j] = acc[j][eng_shift];
  end

  // Checking
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stimulus state shared with the monitor
  logic [IN_DIM-1:0] cur_img;
  int unsigned       shv [NUM_LAYERS];

  // Reference: full network evaluated neuron by neuron from the ROM contents
  function automatic logic [HID_DIM-1:0] ref_mlp(input logic [IN_DIM-1:0] img);
    bit cur [IN_DIM];
    bit nxt [HID_DIM];
    int unsigned base, n_in, cnt;
    logic [PAR-1:0] w;
    logic [HID_DIM-1:0] res;
    base = 0;
    n_in = IN_DIM;
    for (int unsigned i = 0; i < IN_DIM; i++) cur[i] = img[i];
    for (int unsigned n = 0; n < HID_DIM; n++) nxt[n] = 1'b0;
    for (int unsigned l = 0; l < NUM_LAYERS; l++) begin
      for (int unsigned n = 0; n < HID_DIM; n++) begin
        cnt = 0;
        for (int unsigned i = 0; i < n_in; i++) begin
          w = rom[base + (n / PAR) * n_in + i];
          if (cur[i] == w[n % PAR]) cnt++;
        end
        nxt[n] = ((cnt >> shv[l]) & 1) != 0;
      end
      base += NGRP * n_in;
      n_in = HID_DIM;
      for (int unsigned n = 0; n < HID_DIM; n++) cur[n] = nxt[n];
    end
    for (int unsigned n = 0; n < HID_DIM; n++) res[n] = nxt[n];
    return res;
  endfunction

  function automatic logic [SCFG_W-1:0] pack_shifts();
    logic [SCFG_W-1:0] v;
    v = '0;
    for (int unsigned l = 0; l < NUM_LAYERS; l++) v[l*SHIFT_W +: SHIFT_W] = SHIFT_W'(shv[l]);
    return v;
  endfunction

  // Cycle monitor: weight address sequence, ROM/engine alignment, layer and shift tracking
  int unsigned addr_errs = 0, align_errs = 0, lyr_errs = 0, shift_errs = 0;
  int unsigned inp_errs = 0, len_errs = 0, total_en = 0, n_reads = 0;

  initial begin
    int unsigned exp_addr, prev_addr, bursts, kk, lyr;
    bit prev_en, have_prev;
    exp_addr = 0; prev_addr = 0; bursts = 0; kk = 0; prev_en = 0; have_prev = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || !busy) begin
        exp_addr = 0; n_reads = 0; bursts = 0; kk = 0; prev_en = 0; have_prev = 0;
      end else begin
        if (eng_en) begin
          total_en++;
          lyr = bursts / NGRP;
          if (!have_prev || eng_w !== rom[prev_addr]) align_errs++;
          if (int'(layer_idx) != lyr) lyr_errs++;
          if (lyr >= NUM_LAYERS || int'(eng_shift) != shv[lyr]) shift_errs++;
          if (bursts < NGRP && (kk >= IN_DIM || eng_input !== cur_img[kk])) inp_errs++;
          kk++;
        end else if (prev_en) begin
          if (kk != ((bursts < NGRP) ? IN_DIM : HID_DIM)) len_errs++;
          bursts++;
          kk = 0;
        end
        have_prev = w_rd;
        if (w_rd) begin
          if (int'(w_addr) != exp_addr) addr_errs++;
          prev_addr = int'(w_addr);
          exp_addr++;
          n_reads++;
        end
        prev_en = eng_en;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_img();
    for (int unsigned i = 0; i < IN_DIM; i++) cur_img[i] = 1'($urandom_range(1));
  endtask

  task automatic rand_shifts();
    shv[0] = $urandom_range(9);
    for (int unsigned l = 1; l < NUM_LAYERS; l++) shv[l] = $urandom_range(4);
  endtask

  task automatic fixed_shifts();
    shv[0] = 3; shv[1] = 1; shv[2] = 0; shv[3] = 31;
  endtask

  task automatic fill_rom_random();
    for (int unsigned a = 0; a < NW; a++) rom[a] = PAR'($urandom());
  endtask

  task automatic send_words(input int unsigned n, input bit gaps, output bit ok);
    int unsigned guard;
    ok = 1'b1;
    shift_cfg = pack_shifts();
    for (int unsigned w = 0; w < n; w++) begin
      if (gaps) while ($urandom_range(3) == 0) begin in_valid = 1'b0; tick(); end
      in_valid = 1'b1;
      in_data  = cur_img[w*PAR +: PAR];
      guard = 0;
      while (!in_ready && guard < 64) begin tick(); guard++; end
      if (!in_ready) begin
        check_eq("in_ready_wait", 64'(in_ready), 64'(1));
        in_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      tick();
      // Must be ignored: the shifts were latched with the first word.
      if (w == 0) shift_cfg = SCFG_W'($urandom());
    end
    in_valid = 1'b0;
  endtask

  task automatic run_image(input string tag, input bit gaps);
    logic [HID_DIM-1:0] exp_res;
    int unsigned c, cap_cyc;
    bit ok;
    exp_res = ref_mlp(cur_img);
    send_words(NWORDS, gaps, ok);
    if (!ok) return;
    check_eq({tag, "_in_ready_low"}, 64'(in_ready), 64'(0));
    check_eq({tag, "_clear"},        64'(eng_clr),  64'(1));
    check_eq({tag, "_first_addr"},   64'(w_addr),   64'(0));
    c = 0;
    cap_cyc = 0;
    while (!res_valid && c < DONE_LAT + 200) begin
      tick();
      c++;
      if (cap_cyc == 0 && !eng_en && !eng_clr && !res_valid) cap_cyc = c;
    end
    check_eq({tag, "_capture_cyc"}, 64'(cap_cyc),  64'(IN_DIM + 1));
    check_eq({tag, "_done_cyc"},    64'(c),        64'(DONE_LAT));
    check_eq({tag, "_res_data"},    64'(res_data), 64'(exp_res));
    check_eq({tag, "_reads"},       64'(n_reads),  64'(NW));
  endtask

  task automatic finish_image(input string tag);
    res_ready = 1'b1;
    tick();
    check_eq({tag, "_ack_valid"}, 64'(res_valid), 64'(0));
    check_eq({tag, "_ack_busy"},  64'(busy),      64'(0));
    res_ready = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    in_valid  = 1'b0;
    res_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_eq({tag, "_busy"},      64'(busy),      64'(0));
    check_eq({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    check_eq({tag, "_w_rd"},      64'(w_rd),      64'(0));
    check_eq({tag, "_in_ready"},  64'(in_ready),  64'(0));
    check_eq({tag, "_res_data"},  64'(res_data),  64'(0));
    check_eq({tag, "_layer"},     64'(layer_idx), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    check_eq({tag, "_ready_rel"}, 64'(in_ready),  64'(1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HID_DIM-1:0] hold_ref;
    int unsigned hold_errs;
    bit ok;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0; shift_cfg = '0;
    fill_rom_random();
    fixed_shifts();
    cur_img = '0;
    repeat (3) tick();
    check_eq("rst_busy",      64'(busy),      64'(0));
    check_eq("rst_res_valid", 64'(res_valid), 64'(0));
    check_eq("rst_w_rd",      64'(w_rd),      64'(0));
    check_eq("rst_w_addr",    64'(w_addr),    64'(0));
    check_eq("rst_in_ready",  64'(in_ready),  64'(0));
    rst = 1'b0;
    #1;
    check_eq("rel_in_ready",  64'(in_ready),  64'(1));
    tick();

    // All-ones image, back-to-back words
    cur_img = '1;
    fixed_shifts();
    run_image("ones", 1'b0);
    finish_image("ones");

    // Reset while loading (after word 50)
    rand_img(); rand_shifts();
    send_words(50, 1'b0, ok);
    reset_check("rst_load");

    // Reset during the first accumulation pass (k = 300)
    rand_img(); rand_shifts();
    send_words(NWORDS, 1'b0, ok);
    repeat (301) tick();
    check_eq("accum_en_before_rst", 64'(eng_en), 64'(1));
    reset_check("rst_accum");
    tick();

    // ROM returns its own address bits: alignment of eng_w with issued reads
    for (int unsigned a = 0; a < NW; a++) rom[a] = PAR'(a);
    rand_img(); rand_shifts();
    run_image("rompat", 1'b1);
    finish_image("rompat");
    fill_rom_random();

    // Result held while res_ready is low; input ignored in DONE
    rand_img(); rand_shifts();
    hold_ref = ref_mlp(cur_img);
    run_image("hold", 1'b1);
    hold_errs = 0;
    for (int unsigned i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_data  = PAR'($urandom());
      tick();
      if (res_valid !== 1'b1 || res_data !== hold_ref || in_ready !== 1'b0 || busy !== 1'b1)
        hold_errs++;
    end
    in_valid = 1'b0;
    check_eq("hold_stable", 64'(hold_errs), 64'(0));
    finish_image("hold");
    rand_img(); rand_shifts();
    run_image("after_hold", 1'b0);

    // Reset while in DONE
    reset_check("rst_done");
    tick();

    // Random images against the reference model
    for (int unsigned n = 0; n < 20; n++) begin
      rand_img();
      if (n < 5) fixed_shifts();
      else rand_shifts();
      run_image($sformatf("img%0d", n), 1'b1);
      finish_image($sformatf("img%0d", n));
    end

    check_eq("monitor_active", 64'(total_en > 0), 64'(1));
    check_eq("addr_seq",       64'(addr_errs),    64'(0));
    check_eq("w_align",        64'(align_errs),   64'(0));
    check_eq("layer_idx_seq",  64'(lyr_errs),     64'(0));
    check_eq("shift_seq",      64'(shift_errs),   64'(0));
    check_eq("input_bits",     64'(inp_errs),     64'(0));
    check_eq("accum_len",      64'(len_errs),     64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fcl_bin_seq.md
Name: fcl_bin_seq

Overview:
Sequencer that runs a full binary MLP inference (IN_DIM -> HID_DIM x (NUM_LAYERS-1) -> output) through one shared fcl_bin engine.
- Accepts a packed binary input image and buffers it.
- Streams neuron bits and weight words into the engine, one bit per cycle.
- Clears the engine per output group, captures group results into ping-pong hidden buffers, and applies per-layer shift.
- Returns the final layer's bits through a valid/ready port.
- Sits between the input DMA/weight ROM and the fcl_bin datapath.

Parameters:
- PAR, 8, output neurons per engine pass (engine BIN_PARALLEL).
- IN_DIM, 784, input-layer neurons; must be a multiple of PAR.
- HID_DIM, 16, neurons in every computed layer, including the last (padded); multiple of PAR.
- NUM_LAYERS, 4, computed layers.
- SHIFT_W, 5, engine shift width (clog2 of accumulator width).
- WADDR_W, 11, weight address width; must be at least clog2(IN_DIM*HID_DIM/PAR + (NUM_LAYERS-1)*HID_DIM*HID_DIM/PAR).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid&&in_ready.
- in_data  in  PAR  input bits; bit j = neuron word*PAR+j.
- shift_cfg  in  NUM_LAYERS*SHIFT_W  per-layer shift; layer L at [L*SHIFT_W +: SHIFT_W].
- w_addr  out  WADDR_W  weight ROM address.
- w_rd  out  1  weight read strobe.
- w_rdata  in  PAR  weight word; 1-cycle synchronous read latency.
- eng_clr  out  1  engine accumulator clear (wire inverted to fcl_bin rst).
- eng_en  out  1  engine accumulate enable.
- eng_input  out  1  current input neuron bit.
- eng_w  out  PAR  weight word to engine (= w_rdata).
- eng_shift  out  SHIFT_W  current layer shift.
- eng_output  in  PAR  engine result bits.
- res_valid  out  1  final result valid.
- res_ready  in  1  result consumed.
- res_data  out  HID_DIM  final layer bits.
- busy  out  1  high in every state except IDLE.
- layer_idx  out  clog2(NUM_LAYERS)  layer in progress.

Behaviour:
- Reset (async, any state): state IDLE; all counters, buffers and outputs 0; in_ready=0 during reset, 1 after release.
- States: IDLE, LOAD, CLEAR, ACCUM, CAPTURE, DONE.
- IDLE: in_ready=1. On the first handshake, store the word at image index 0, latch shift_cfg, go to LOAD.
- LOAD: in_ready=1. Store words sequentially. After word IN_DIM/PAR-1 is accepted, go to CLEAR next cycle with in_ready=0. in_valid outside IDLE/LOAD is ignored.
- CLEAR (1 cycle): eng_clr=1, eng_en=0, w_rd=1, w_addr=current weight pointer (input 0 of the group).
- ACCUM (N_in cycles, k=0..N_in-1):
  - eng_en=1, eng_input=src_buf[k], eng_w=w_rdata for address issued the previous cycle.
  - w_rd=1 with the next address while k<N_in-1.
  - N_in=IN_DIM for layer 0, HID_DIM otherwise.
- CAPTURE (1 cycle): eng_en=0; register eng_output into dst_buf[group*PAR +: PAR].
  - If more groups remain: go to CLEAR.
  - Else if more layers remain: swap src/dst hidden buffers, layer_idx++, go to CLEAR.
  - Else: go to DONE.
- Buffers: layer 0 source = image buffer. Layers then alternate between hidden buffers H0/H1; layer 0 writes H0.
- Weight pointer: linear from 0, increments once per issued read, never resets between groups or layers. Order is layer, group, input.
- Group cost N_in+2 cycles. With defaults, DONE is entered exactly 1680 cycles after the first CLEAR cycle (2*786 + 6*18).
- eng_shift = latched shift for layer_idx; stable for the whole layer.
- DONE: res_valid=1 and res_data = last dst buffer, both held until res_ready. On handshake, go to IDLE the next cycle with res_valid=0.
- Reset mid-operation: immediate abort, no partial result; the next image starts at weight address 0.

Test Plan:
- Reset in each state (LOAD word 50, ACCUM k=300, DONE) -> next cycle IDLE, busy=0, res_valid=0, w_rd=0, in_ready=1 after release.
- All-ones image, 98 back-to-back words -> in_ready drops after word 98; CLEAR cycle w_addr=0; ACCUM spans 784 cycles with w_addr 1..783; CAPTURE at cycle 785.
- Random image with gaps in in_valid -> image buffer matches the sent words; weight address sequence is 0..1663 with no gaps or repeats; res_valid at cycle 1680 after first CLEAR.
- Reference engine model with shift_cfg layers = {3,1,0,31} -> eng_shift changes only at layer boundaries; res_data matches the golden model for 20 random images.
- res_ready held low for 50 cycles in DONE -> res_data and res_valid stable; in_valid ignored; a new image is accepted only after the handshake.
- Weight ROM returns addr[PAR-1:0] -> eng_w during ACCUM cycle k equals the word for address issued at k-1 (1-cycle alignment check).
